eot_gen_nd: RTL and testbench
=============================

# eot_gen_nd

Parametrised successor end-of-transfer tagger for the cascade classifier pixel streams. It passes a valid/ready data stream through unchanged and tags each beat with row, window and burst end markers plus x/y coordinates. Window width, window height and windows-per-burst are loaded at run time through a config handshake. It sits between the image/integral-image feeders and the feature evaluators, in place of fixed-size tagging.

## Interface
- W_DATA, 8, data width
- MAX_WIDTH, 24, largest window width supported
- MAX_HEIGHT, 24, largest window height supported
- MAX_WINDOWS, 1024, largest windows-per-burst count
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_width  in  $clog2(MAX_WIDTH+1)  window width in pixels
- cfg_height  in  $clog2(MAX_HEIGHT+1)  window height in rows
- cfg_windows  in  $clog2(MAX_WINDOWS+1)  windows in the burst
- din_valid / din_ready / din_data  in/out/in  1/1/W_DATA  input stream
- dout_valid / dout_ready / dout_data  out/in/out  1/1/W_DATA  output stream
- dout_eot  out  3  [0] last pixel of row, [1] last pixel of window, [2] last pixel of burst
- dout_x  out  $clog2(MAX_WIDTH)  column of the beat
- dout_y  out  $clog2(MAX_HEIGHT)  row of the beat
- busy  out  1  high in RUN

## Operation
- FSM states: IDLE, RUN.
- IDLE:
  - cfg_ready=1, din_ready=0.
  - On cfg_valid, the block latches the three cfg values, clears x/y/window counters and moves to RUN.
- Config clamping:
  - A value of 0 is treated as 1.
  - A value above its MAX is treated as MAX.
  - Clamping is applied when the value is latched.
- RUN:
  - cfg_ready=0.
  - Each input handshake emits one output beat carrying dout_x=x and dout_y=y, then advances the counters.
  - x==w-1 sets eot[0] and wraps x to 0. Otherwise x increments.
  - When x wraps and y==h-1: set eot[1], wrap y to 0, increment the window counter. Otherwise y increments on the x wrap.
  - When eot[1] is set and win==n-1: set eot[2] and return to IDLE on that handshake.
- eot bits are nested: eot[2] implies eot[1], and eot[1] implies eot[0].
- Data is never modified, dropped or duplicated.
- Counters advance only on an input handshake. They hold through stalls and through gaps in din_valid.
- rst in any state:
  - Returns to IDLE and clears all counters.
  - Any beat in flight is discarded.

## Timing
- Reset values: cfg_ready=1, din_ready=0, dout_valid=0, dout_eot=0, dout_x=0, dout_y=0, busy=0.
- Config is accepted in one cycle. The first pixel can be accepted on the next cycle.
- Pass-through mode (macro undefined):
  - dout_valid = din_valid & RUN.
  - din_ready = dout_ready & RUN.
  - Zero latency. dout_eot, dout_x and dout_y are combinational from the counters.
- The burst-final handshake and a new cfg handshake never overlap, so at least one idle cycle separates bursts.

## Configuration
- EOT_GEN_ND_OUT_REG_EN defined:
  - All outputs (data, eot, x, y) pass through a 2-entry skid buffer.
  - Latency is 1 cycle at full throughput.
  - din_ready = skid-ready & RUN, so din_ready does not depend combinationally on dout_ready.
  - A beat held in the buffer is still delivered after the FSM returns to IDLE.
  - cfg_ready is additionally gated by the buffer being empty.
- EOT_GEN_ND_OUT_REG_EN undefined: pass-through as described under Timing.

## Structure
- Package eot_gen_pkg holds:
  - state enum (IDLE, RUN);
  - eot bit index constants EOT_ROW=0, EOT_WIN=1, EOT_BURST=2;
  - a packed beat struct {data, eot, x, y} parametrised through localparam widths.
- Sub-module skid_buffer (width-generic, 2 entries) is instantiated only under the macro.

## Test plan
- cfg 4x3, windows=2, continuous valid and ready:
  - 24 beats;
  - eot[0] on beats 4,8,…,24;
  - eot[1] on beats 12 and 24;
  - eot[2] on beat 24 only;
  - busy drops the cycle after beat 24.
- cfg width=0, height=30, windows=1:
  - clamps to 1x24;
  - every beat has eot[0];
  - eot[1]|eot[2] on beat 24;
  - dout_x always 0.
- Random dout_ready stalls (50%) on 24x24x3:
  - 1728 beats, in order;
  - x/y/eot match the reference model;
  - no loss or duplication.
- din_valid held low in IDLE, and cfg_valid held high during RUN:
  - din_ready stays 0 in IDLE;
  - cfg_ready stays 0 until the burst ends;
  - the new cfg is taken the cycle after the final beat.
- rst pulsed mid-window at x=2,y=1:
  - next cycle is IDLE with all outputs at reset values;
  - after a new cfg, the first beat has x=0,y=0.
- With EOT_GEN_ND_OUT_REG_EN, the first case is repeated:
  - identical beat sequence delayed 1 cycle;
  - a full 24-beat burst completes in 25 cycles with dout_ready held high.

Source files
------------

// File: rtl/eot_gen_pkg.sv
// Shared types for the end-of-transfer tagger: FSM states, eot bit positions,
// the output beat layout and the config clamp helper.
package eot_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int EOT_ROW   = 0;
  localparam int EOT_WIN   = 1;
  localparam int EOT_BURST = 2;

  localparam int BEAT_W_DATA = 8;
  localparam int BEAT_W_X    = 5;
  localparam int BEAT_W_Y    = 5;

  typedef struct packed {
    logic [BEAT_W_DATA-1:0] data;
    logic [2:0]             eot;
    logic [BEAT_W_X-1:0]    x;
    logic [BEAT_W_Y-1:0]    y;
  } beat_t;

  // Zero means one; anything beyond the supported maximum saturates.
  function automatic int unsigned clamp_cfg(input int unsigned v, input int unsigned vmax);
    if (v == 0)
      return 1;
    else if (v > vmax)
      return vmax;
    else
      return v;
  endfunction

endpackage

// File: rtl/eot_gen_nd_skid_buffer.sv
// Two-entry skid buffer: registered outputs, upstream ready depends only on
// local state.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_empty
);

  logic         r_v0;
  logic         r_v1;
  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic         w_push;
  logic         w_pop;

  assign o_ready = ~r_v1;
  assign o_valid = r_v0;
  assign o_data  = r_d0;
  assign o_empty = ~r_v0 & ~r_v1;
  assign w_push  = i_valid & ~r_v1;
  assign w_pop   = r_v0 & i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
    end else if (!r_v0 || w_pop) begin
      if (r_v1) begin
        r_d0 <= r_d1;
        r_v0 <= 1'b1;
        r_v1 <= 1'b0;
      end else begin
        r_v0 <= w_push;
        if (w_push)
          r_d0 <= i_data;
      end
    end else if (w_push) begin
      // Output stalled: park the new beat in the skid slot.
      r_d1 <= i_data;
      r_v1 <= 1'b1;
    end
  end

endmodule

// File: rtl/eot_gen_nd.sv
// Run-time sized end-of-transfer tagger: passes a stream through and marks
// row/window/burst ends with x/y. Optional output register: EOT_GEN_ND_OUT_REG_EN.
//
// state | meaning
// IDLE  | waiting for a config handshake; input stream blocked
// RUN   | tagging beats until the last pixel of the last window
module eot_gen_nd
  import eot_gen_pkg::*;
#(
  parameter int W_DATA      = 8,
  parameter int MAX_WIDTH   = 24,
  parameter int MAX_HEIGHT  = 24,
  parameter int MAX_WINDOWS = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]     cfg_width,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0]    cfg_height,
  input  logic [$clog2(MAX_WINDOWS+1)-1:0]   cfg_windows,
  input  logic                               din_valid,
  output logic                               din_ready,
  input  logic [W_DATA-1:0]                  din_data,
  output logic                               dout_valid,
  input  logic                               dout_ready,
  output logic [W_DATA-1:0]                  dout_data,
  output logic [2:0]                         dout_eot,
  output logic [$clog2(MAX_WIDTH)-1:0]       dout_x,
  output logic [$clog2(MAX_HEIGHT)-1:0]      dout_y,
  output logic                               busy
);

  localparam int W_X = $clog2(MAX_WIDTH);
  localparam int W_Y = $clog2(MAX_HEIGHT);
  localparam int W_N = $clog2(MAX_WINDOWS);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W_X-1:0] r_x;
  logic [W_X-1:0] r_w_m1;
  logic [W_Y-1:0] r_y;
  logic [W_Y-1:0] r_h_m1;
  logic [W_N-1:0] r_win;
  logic [W_N-1:0] r_n_m1;
  logic           w_run;
  logic           w_hs;
  logic           w_cfg_hs;
  logic           w_up_ready;
  logic           w_buf_empty;
  logic [2:0]     w_eot;

  assign w_run     = (r_state == RUN);
  assign busy      = w_run;
  assign din_ready = w_up_ready & w_run;
  assign w_hs      = din_valid & din_ready;
  assign cfg_ready = ~w_run & w_buf_empty;
  assign w_cfg_hs  = cfg_valid & cfg_ready;

  always_comb begin
    w_eot            = '0;
    w_eot[EOT_ROW]   = w_run && (r_x == r_w_m1);
    w_eot[EOT_WIN]   = w_eot[EOT_ROW] && (r_y == r_h_m1);
    w_eot[EOT_BURST] = w_eot[EOT_WIN] && (r_win == r_n_m1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cfg_hs) w_state_nxt = RUN;
      RUN:     if (w_hs && w_eot[EOT_BURST]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Limits are stored as (value - 1) so the terminal compare is a plain equality.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_win  <= '0;
      r_w_m1 <= '0;
      r_h_m1 <= '0;
      r_n_m1 <= '0;
    end else if (w_cfg_hs) begin
      r_x    <= '0;
      r_y    <= '0;
      r_win  <= '0;
      r_w_m1 <= W_X'(clamp_cfg(32'(cfg_width), MAX_WIDTH) - 32'd1);
      r_h_m1 <= W_Y'(clamp_cfg(32'(cfg_height), MAX_HEIGHT) - 32'd1);
      r_n_m1 <= W_N'(clamp_cfg(32'(cfg_windows), MAX_WINDOWS) - 32'd1);
    end else if (w_hs) begin
      if (w_eot[EOT_ROW]) begin
        r_x <= '0;
        if (w_eot[EOT_WIN]) begin
          r_y <= '0;
          if (w_eot[EOT_BURST])
            r_win <= '0;
          else
            r_win <= r_win + 1'b1;
        end else begin
          r_y <= r_y + 1'b1;
        end
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

`ifdef EOT_GEN_ND_OUT_REG_EN
  localparam int W_BEAT = W_DATA + 3 + W_X + W_Y;

  logic [W_BEAT-1:0] w_beat_in;
  logic [W_BEAT-1:0] w_beat_out;
  logic              w_buf_in_valid;

  assign w_beat_in      = {din_data, w_eot, r_x, r_y};
  assign w_buf_in_valid = din_valid & w_run;

  skid_buffer #(
    .W (W_BEAT)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_buf_in_valid),
    .i_data  (w_beat_in),
    .o_ready (w_up_ready),
    .o_valid (dout_valid),
    .i_ready (dout_ready),
    .o_data  (w_beat_out),
    .o_empty (w_buf_empty)
  );

  assign {dout_data, dout_eot, dout_x, dout_y} = w_beat_out;
`else
  assign w_up_ready  = dout_ready;
  assign w_buf_empty = 1'b1;
  assign dout_valid  = din_valid & w_run;
  assign dout_data   = din_data;
  assign dout_eot    = w_eot;
  assign dout_x      = r_x;
  assign dout_y      = r_y;
`endif

endmodule

// File: tb/tb_eot_gen_nd.sv
// Scoreboard bench for eot_gen_nd: expected beats are queued when offered and
// compared when the DUT emits them.
module tb_eot_gen_nd;
  import eot_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [4:0]  cfg_width;
  logic [4:0]  cfg_height;
  logic [10:0] cfg_windows;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  din_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [7:0]  dout_data;
  logic [2:0]  dout_eot;
  logic [4:0]  dout_x;
  logic [4:0]  dout_y;
  logic        busy;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  eot_gen_nd #(
    .W_DATA      (8),
    .MAX_WIDTH   (24),
    .MAX_HEIGHT  (24),
    .MAX_WINDOWS (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .cfg_windows (cfg_windows),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .din_data    (din_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_eot    (dout_eot),
    .dout_x      (dout_x),
    .dout_y      (dout_y),
    .busy        (busy)
  );

  function automatic logic [7:0] data_of(input int idx);
    return 8'(idx * 37 + 5);
  endfunction

  function automatic beat_t model(input int idx, input int w, input int h, input int n);
    beat_t b;
    int x   = idx % w;
    int y   = (idx / w) % h;
    int win = idx / (w * h);
    b.data   = data_of(idx);
    b.x      = 5'(x);
    b.y      = 5'(y);
    b.eot[0] = (x == w - 1);
    b.eot[1] = b.eot[0] && (y == h - 1);
    b.eot[2] = b.eot[1] && (win == n - 1);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int w, input int h, input int n);
    bit done = 0;
    cfg_width   = 5'(w);
    cfg_height  = 5'(h);
    cfg_windows = 11'(n);
    cfg_valid   = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cfg_ready) done = 1;
      step();
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL cfg_timeout: cfg_ready stayed %b, expected 1 within 50 cycles", cfg_ready);
    end
  endtask

  task automatic stream(input int w, input int h, input int n, input int rdy_pct,
                        input int vld_pct, input int stop_at, input bit hold_cfg,
                        output int cycles, output bit last_busy);
    int total  = w * h * n;
    int budget = total * 10 + 100;
    int idx    = 0;
    int offered = -1;
    int got    = 0;
    beat_t e;
    cycles    = 0;
    last_busy = 0;
    while (got < total && (stop_at < 0 || idx < stop_at) && cycles < budget) begin
      if (idx < total && $urandom_range(99) < vld_pct) begin
        din_valid = 1'b1;
        din_data  = data_of(idx);
        if (offered != idx) begin
          exp_q.push_back(model(idx, w, h, n));
          offered = idx;
        end
      end else begin
        din_valid = 1'b0;
        din_data  = 8'($urandom);
      end
      dout_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      cycles++;
      if (hold_cfg) begin
        n_checks++;
        if (cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL cfg_ready_run: got %b, expected 0 at cycle %0d", cfg_ready, cycles);
        end
      end
      if (dout_valid && dout_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got data=%h x=%0d y=%0d, expected no beat", dout_data, dout_x, dout_y);
        end else begin
          e = exp_q.pop_front();
          if ({dout_data, dout_eot, dout_x, dout_y} !== e) begin
            n_fail++;
            $display("FAIL beat %0d: got data=%h eot=%b x=%0d y=%0d, expected data=%h eot=%b x=%0d y=%0d",
                     got, dout_data, dout_eot, dout_x, dout_y, e.data, e.eot, e.x, e.y);
          end
        end
        got++;
        last_busy = busy;
      end
      if (din_valid && din_ready) idx++;
      step();
    end
    din_valid = 1'b0;
    n_checks++;
    if (cycles >= budget) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d beats, expected %0d within %0d cycles", got, total, budget);
    end
  endtask

  task automatic check_queue_empty(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover: %0d beats outstanding, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    din_valid  = 1'b1;
    din_data   = 8'h3C;
    dout_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if ({cfg_ready, din_ready, dout_valid, dout_eot, dout_x, dout_y, busy} !== {1'b1, 1'b0, 1'b0, 3'b0, 5'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got cfg_ready=%b din_ready=%b dout_valid=%b eot=%b x=%0d y=%0d busy=%b, expected 1 0 0 000 0 0 0",
               cfg_ready, din_ready, dout_valid, dout_eot, dout_x, dout_y, busy);
    end
    step();
    rst       = 1'b0;
    din_valid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int cycles;
    bit lb;
    do_cfg(4, 3, 2);
    stream(4, 3, 2, 100, 100, -1, 1'b0, cycles, lb);
    check_queue_empty("basic");
    n_checks++;
`ifdef EOT_GEN_ND_OUT_REG_EN
    if (cycles != 25) begin
      n_fail++;
      $display("FAIL basic_cycles: got %0d, expected 25", cycles);
    end
`else
    if (cycles != 24) begin
      n_fail++;
      $display("FAIL basic_cycles: got %0d, expected 24", cycles);
    end
    n_checks++;
    if (lb !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_last: got %b, expected 1", lb);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_after: got %b, expected 0", busy);
    end
    step();
  endtask

  task automatic test_clamp();
    int cycles;
    bit lb;
    do_cfg(0, 30, 1);
    stream(1, 24, 1, 100, 100, -1, 1'b0, cycles, lb);
    check_queue_empty("clamp");
    step();
  endtask

  task automatic test_stalls();
    int cycles;
    bit lb;
    do_cfg(24, 24, 3);
    stream(24, 24, 3, 50, 75, -1, 1'b0, cycles, lb);
    check_queue_empty("stalls");
    step();
  endtask

  task automatic test_cfg_hold();
    int cycles;
    bit lb;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (din_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_din_ready: got %b, expected 0", din_ready);
      end
      step();
    end
    do_cfg(2, 2, 1);
    cfg_width   = 5'd3;
    cfg_height  = 5'd1;
    cfg_windows = 11'd1;
    cfg_valid   = 1'b1;
    stream(2, 2, 1, 100, 100, -1, 1'b1, cycles, lb);
    check_queue_empty("hold1");
    @(negedge clk);
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_ready_after_burst: got %b, expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_cfg_taken: busy got %b, expected 1", busy);
    end
    step();
    stream(3, 1, 1, 100, 100, -1, 1'b0, cycles, lb);
    check_queue_empty("hold2");
    step();
  endtask

  task automatic test_rst_mid();
    int cycles;
    bit lb;
    beat_t e;
    do_cfg(4, 3, 1);
    stream(4, 3, 1, 100, 100, 6, 1'b0, cycles, lb);
    din_valid  = 1'b1;
    din_data   = 8'hA5;
    dout_ready = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
`ifndef EOT_GEN_ND_OUT_REG_EN
    e = model(6, 4, 3, 1);
    n_checks++;
    if ({dout_x, dout_y} !== {e.x, e.y}) begin
      n_fail++;
      $display("FAIL rst_mid_pos: got x=%0d y=%0d, expected x=%0d y=%0d", dout_x, dout_y, e.x, e.y);
    end
`endif
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cfg_ready, din_ready, dout_valid, dout_eot, dout_x, dout_y, busy} !== {1'b1, 1'b0, 1'b0, 3'b0, 5'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_values: got cfg_ready=%b din_ready=%b dout_valid=%b eot=%b x=%0d y=%0d busy=%b, expected 1 0 0 000 0 0 0",
               cfg_ready, din_ready, dout_valid, dout_eot, dout_x, dout_y, busy);
    end
    exp_q.delete();
    step();
    din_valid = 1'b0;
    do_cfg(4, 3, 1);
    stream(4, 3, 1, 100, 100, -1, 1'b0, cycles, lb);
    check_queue_empty("rst_mid");
    step();
  endtask

  initial begin
    rst         = 1'b1;
    cfg_valid   = 1'b0;
    cfg_width   = '0;
    cfg_height  = '0;
    cfg_windows = '0;
    din_valid   = 1'b0;
    din_data    = '0;
    dout_ready  = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_clamp();
    test_stalls();
    test_cfg_hold();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
